// File: rtl/ticks_speed_window.sv
// Encoder speed measurement: tick delta per fixed window, 4-window running sum and stall detection.
// State table:
//   IDLE  | measurement off, window counter parked at 0
//   PRIME | first window after enable; only captures the reference tick count
//   RUN   | every terminal count publishes a delta and strobes Speed_Valid
module ticks_speed_window #(
  parameter int unsigned WINDOW_CYCLES = 50000,  // must be >= 2 so strobes never touch
  parameter int unsigned STALL_WINDOWS = 4
) (
  input  logic        CLK,
  input  logic        RST_1,
  input  logic        Enable,
  input  logic [8:0]  Ticks,
  output logic [8:0]  Speed,
  output logic        Speed_Valid,
  output logic [10:0] Speed_Avg,
  output logic        Avg_Ready,
  output logic        Stall
);

  localparam int unsigned CW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [CW-1:0] TC = CW'(WINDOW_CYCLES - 1);
  localparam logic [3:0] STALL_N = 4'(STALL_WINDOWS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [8:0]      prev_q;
  logic [2:0][8:0] hist_q;   // three previous deltas; the fourth entry is the incoming one
  logic [1:0]      fill_q;
  logic [3:0]      zrun_q;
  logic [8:0]      speed_q;
  logic            valid_q;
  logic [10:0]     avg_q;
  logic            ready_q;
  logic            stall_q;

  logic            tc;
  logic [8:0]      delta_d;
  logic [10:0]     sum_d;
  logic [3:0]      zrun_d;

  always_comb begin
    tc      = (cnt_q == TC);
    delta_d = Ticks - prev_q;
    sum_d   = {2'b00, delta_d} + {2'b00, hist_q[0]} + {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
    zrun_d  = (zrun_q >= STALL_N) ? zrun_q : zrun_q + 4'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST_1) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prev_q  <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      zrun_q  <= '0;
      speed_q <= '0;
      valid_q <= 1'b0;
      avg_q   <= '0;
      ready_q <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (Enable) state_q <= PRIME;
        end
        PRIME, RUN: begin
          if (!Enable) begin
            // Disable wins over a coincident terminal count; Speed, Speed_Avg and Stall hold.
            state_q <= IDLE;
            cnt_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            zrun_q  <= '0;
            ready_q <= 1'b0;
          end else if (tc) begin
            cnt_q  <= '0;
            prev_q <= Ticks;
            if (state_q == PRIME) begin
              state_q <= RUN;
            end else begin
              speed_q <= delta_d;
              valid_q <= 1'b1;
              hist_q  <= {hist_q[1:0], delta_d};
              avg_q   <= sum_d;
              fill_q  <= (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
              ready_q <= (fill_q == 2'd3);
              if (delta_d == 9'd0) begin
                zrun_q  <= zrun_d;
                stall_q <= stall_q | (zrun_d >= STALL_N);
              end else begin
                zrun_q  <= '0;
                stall_q <= 1'b0;
              end
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Speed       = speed_q;
  assign Speed_Valid = valid_q;
  assign Speed_Avg   = avg_q;
  assign Avg_Ready   = ready_q;
  assign Stall       = stall_q;

endmodule

// File: tb/tb_ticks_speed_window.sv
// Bench for ticks_speed_window (WINDOW_CYCLES=100, STALL_WINDOWS=4): window vectors feed a
// strobe scoreboard; hand sequences cover disable, enable-at-terminal-count and reset.
module tb_ticks_speed_window;

  logic        CLK;
  logic        RST_1;
  logic        Enable;
  logic [8:0]  Ticks;
  logic [8:0]  Speed;
  logic        Speed_Valid;
  logic [10:0] Speed_Avg;
  logic        Avg_Ready;
  logic        Stall;

  ticks_speed_window #(.WINDOW_CYCLES(100), .STALL_WINDOWS(4)) dut (
    .CLK(CLK), .RST_1(RST_1), .Enable(Enable), .Ticks(Ticks),
    .Speed(Speed), .Speed_Valid(Speed_Valid), .Speed_Avg(Speed_Avg),
    .Avg_Ready(Avg_Ready), .Stall(Stall)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int         tag;
    int         inc;
    logic [8:0]  speed;
    logic [10:0] avg;
    logic        ready;
    logic        stall;
  } vec_t;

  vec_t tbl [13];
  vec_t sb_q [$];
  vec_t mon_e;
  vec_t man_e;

  int checks = 0;
  int errors = 0;

  bit          mon_en = 1'b0;
  bit          sv_prev = 1'b0;
  logic        rst_at_edge = 1'b0;
  logic [8:0]  spd_last = '0;
  logic [10:0] avg_last = '0;
  logic        stall_last = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge CLK) rst_at_edge <= RST_1;

  // Scoreboard: each strobe pops the next expected record.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (Speed_Valid) begin
        chk("strobe_back_to_back", int'(sv_prev), 0);
        if (sb_q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          chk($sformatf("speed[%0d]", mon_e.tag), int'(Speed), int'(mon_e.speed));
          chk($sformatf("avg[%0d]", mon_e.tag), int'(Speed_Avg), int'(mon_e.avg));
          chk($sformatf("ready[%0d]", mon_e.tag), int'(Avg_Ready), int'(mon_e.ready));
          chk($sformatf("stall[%0d]", mon_e.tag), int'(Stall), int'(mon_e.stall));
        end
      end else if (!rst_at_edge) begin
        chk("hold_without_strobe",
            int'(Speed != spd_last || Speed_Avg != avg_last || Stall != stall_last), 0);
      end
      sv_prev    = Speed_Valid;
      spd_last   = Speed;
      avg_last   = Speed_Avg;
      stall_last = Stall;
    end
  end

  // One 100-cycle window ending just before a terminal-count edge.
  task automatic run_window(input int inc, input bit chk_sv, input bit drop_en);
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (i == 0 && chk_sv) chk("strobe_timing", int'(Speed_Valid), 1);
      if (inc <= 10) begin
        if (i % 10 == 5 && i / 10 < inc) Ticks = Ticks + 9'd1;
      end else if (i == 50) begin
        Ticks = Ticks + 9'(inc);
      end
      if (drop_en && i == 99) Enable = 1'b0;
    end
  endtask

  task automatic push(input int tag, input int spd, input int avg, input bit rdy, input bit stl);
    man_e.tag   = tag;
    man_e.inc   = 0;
    man_e.speed = 9'(spd);
    man_e.avg   = 11'(avg);
    man_e.ready = rdy;
    man_e.stall = stl;
    sb_q.push_back(man_e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // tag, inc, speed, avg, ready, stall
    tbl = '{
      '{0,  10,  9'd10,  11'd10,   1'b0, 1'b0},
      '{1,  10,  9'd10,  11'd20,   1'b0, 1'b0},
      '{2,  10,  9'd10,  11'd30,   1'b0, 1'b0},
      '{3,  10,  9'd10,  11'd40,   1'b1, 1'b0},
      '{4,  25,  9'd25,  11'd55,   1'b1, 1'b0},
      '{5,  0,   9'd0,   11'd45,   1'b1, 1'b0},
      '{6,  0,   9'd0,   11'd35,   1'b1, 1'b0},
      '{7,  0,   9'd0,   11'd25,   1'b1, 1'b0},
      '{8,  0,   9'd0,   11'd0,    1'b1, 1'b1},
      '{9,  7,   9'd7,   11'd7,    1'b1, 1'b0},
      '{10, 200, 9'd200, 11'd207,  1'b1, 1'b0},
      '{11, 300, 9'd300, 11'd507,  1'b1, 1'b0},
      '{12, 511, 9'd511, 11'd1018, 1'b1, 1'b0}
    };

    RST_1  = 1'b1;
    Enable = 1'b0;
    Ticks  = 9'd495;
    repeat (3) @(negedge CLK);
    chk("rst_speed", int'(Speed), 0);
    chk("rst_valid", int'(Speed_Valid), 0);
    chk("rst_avg", int'(Speed_Avg), 0);
    chk("rst_ready", int'(Avg_Ready), 0);
    chk("rst_stall", int'(Stall), 0);
    mon_en = 1'b1;

    // Enable with reset release: prime captures 505, first run window wraps 505 -> 3.
    RST_1  = 1'b0;
    Enable = 1'b1;
    run_window(10, 1'b0, 1'b0);
    for (int k = 0; k < 13; k++) begin
      run_window(tbl[k].inc, k > 0, 1'b0);
      sb_q.push_back(tbl[k]);
    end

    // Disable at counter 50 of a RUN window.
    repeat (51) @(negedge CLK);
    chk("dis_first_negedge_pending", sb_q.size(), 0);
    Enable = 1'b0;
    repeat (300) @(negedge CLK);
    chk("dis_ready", int'(Avg_Ready), 0);
    chk("dis_speed_held", int'(Speed), 511);
    chk("dis_avg_held", int'(Speed_Avg), 1018);
    chk("dis_stall", int'(Stall), 0);

    // Re-enable: prime then first strobe, history restarted from zero.
    Enable = 1'b1;
    run_window(5, 1'b0, 1'b0);
    run_window(5, 1'b0, 1'b0);
    push(100, 5, 5, 1'b0, 1'b0);

    // Enable drops on the terminal-count edge: no strobe, Speed keeps 5.
    run_window(9, 1'b1, 1'b1);
    repeat (20) @(negedge CLK);
    chk("tcdrop_speed", int'(Speed), 5);
    chk("tcdrop_avg", int'(Speed_Avg), 5);
    chk("tcdrop_ready", int'(Avg_Ready), 0);

    // Four frozen windows raise Stall, then reset at counter 70 clears everything.
    Enable = 1'b1;
    run_window(3, 1'b0, 1'b0);
    run_window(0, 1'b0, 1'b0);
    push(101, 0, 0, 1'b0, 1'b0);
    run_window(0, 1'b1, 1'b0);
    push(102, 0, 0, 1'b0, 1'b0);
    run_window(0, 1'b1, 1'b0);
    push(103, 0, 0, 1'b0, 1'b0);
    run_window(0, 1'b1, 1'b0);
    push(104, 0, 0, 1'b1, 1'b1);
    repeat (71) @(negedge CLK);
    chk("pre_rst_stall", int'(Stall), 1);
    RST_1 = 1'b1;
    @(negedge CLK);
    chk("midrst_speed", int'(Speed), 0);
    chk("midrst_valid", int'(Speed_Valid), 0);
    chk("midrst_avg", int'(Speed_Avg), 0);
    chk("midrst_ready", int'(Avg_Ready), 0);
    chk("midrst_stall", int'(Stall), 0);
    RST_1 = 1'b0;
    run_window(4, 1'b0, 1'b0);
    run_window(12, 1'b0, 1'b0);
    push(105, 12, 12, 1'b0, 1'b0);
    @(negedge CLK);
    chk("restart_strobe_timing", int'(Speed_Valid), 1);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge CLK);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ticks_speed_window.md
TICKS_SPEED_WINDOW -- requirements
Module: ticks_speed_window

Interface
REQ-001 SHALL provide parameter WINDOW_CYCLES, default 50000, clock cycles per measurement window (1 ms at 50 MHz CLK).
REQ-002 SHALL provide parameter STALL_WINDOWS, default 4, consecutive zero-delta windows before Stall asserts (range 1..15).
REQ-003 SHALL have port CLK  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port RST_1  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port Enable  input  1  measurement enable, level-sensitive.
REQ-006 SHALL have port Ticks  input  9  free-running encoder tick count from the upstream tick counter, wraps modulo 512.
REQ-007 SHALL have port Speed  output  9  tick delta of the last completed window.
REQ-008 SHALL have port Speed_Valid  output  1  one-cycle strobe marking a new Speed value.
REQ-009 SHALL have port Speed_Avg  output  11  sum of the last four window deltas.
REQ-010 SHALL have port Avg_Ready  output  1  high once four deltas have filled the average history.
REQ-011 SHALL have port Stall  output  1  motor-stalled flag.

Function
REQ-012 SHALL implement states IDLE, PRIME, RUN; window counter counts 0..WINDOW_CYCLES-1 and wraps.
REQ-013 IDLE: window counter held at 0, no strobes; Enable=1 -> PRIME on the next edge.
REQ-014 PRIME: on the terminal-count edge (counter = WINDOW_CYCLES-1) capture Ticks into Prev, go to RUN; no Speed_Valid.
REQ-015 RUN: on each terminal-count edge, Speed <= (Ticks - Prev) mod 512, Prev <= Ticks, Speed_Valid = 1 for exactly the following cycle.
REQ-016 Delta arithmetic SHALL be 9-bit unsigned modular subtraction, so Prev=510, Ticks=4 gives Speed=6.
REQ-017 Speed, Speed_Avg, Avg_Ready and Stall SHALL change only on the same edge that raises Speed_Valid, and hold otherwise.
REQ-018 Speed_Avg SHALL be the zero-extended 11-bit sum of a 4-entry delta history; the new delta enters and the oldest is dropped on each strobe.
REQ-019 Avg_Ready SHALL assert on the 4th RUN strobe after entering PRIME; history entries are zero before that.
REQ-020 Stall SHALL assert on the strobe completing STALL_WINDOWS consecutive zero deltas; it SHALL clear on the first nonzero delta strobe; the run counter saturates.
REQ-021 Enable=0 in PRIME or RUN SHALL return to IDLE on the next edge: counter cleared, history and Avg_Ready cleared, Speed and Stall held, no strobe.
REQ-022 Enable falling on a terminal-count edge SHALL take priority: no strobe, no Speed update.
REQ-023 Re-enable SHALL always pass through PRIME, so the first strobe comes 2*WINDOW_CYCLES cycles after the enable edge.
REQ-024 Speed_Valid SHALL never assert in two consecutive cycles.
REQ-025 Ticks SHALL be sampled directly; it is synchronous to CLK and advances less than 512 per window, and aliasing above that is out of scope.

Reset
REQ-026 RST_1=1 on an edge SHALL force IDLE, window counter=0, Prev=0, history=0, Speed=0, Speed_Valid=0, Speed_Avg=0, Avg_Ready=0, Stall=0.
REQ-027 Reset SHALL override Enable and terminal count on the same edge; reset mid-window discards the partial window.
REQ-028 After RST_1 falls with Enable=1, PRIME SHALL begin on the next edge.

Verification (WINDOW_CYCLES=100, STALL_WINDOWS=4)
REQ-029 Constant rate: Ticks +1 every 10 cycles, Enable=1 from reset -> first Speed_Valid about 200 cycles after enable, Speed=10, and Speed_Avg=40 with Avg_Ready=1 at the 4th strobe.
REQ-030 Wrap-around: Prev=505, Ticks=3 at terminal count -> Speed=10, with no glitch in Speed_Avg.
REQ-031 Stall: Ticks frozen after running -> Stall=1 at the 4th zero strobe with Speed=0; the next +7 window clears Stall and gives Speed=7.
REQ-032 Disable mid-RUN: Enable=0 at counter=50 -> no further strobes, Avg_Ready=0, Speed held; re-enable -> next strobe 200 cycles later.
REQ-033 Reset mid-window: RST_1 pulsed at counter=70 in RUN -> all outputs 0 on the next cycle, and operation restarts through PRIME.
REQ-034 Enable drop coincident with terminal count -> no Speed_Valid and Speed unchanged.
